// File: rtl/fixed_accumulator_if.sv
// Valid/ready stream pair around fixed_accumulator: partial sums in, accumulated results out.
// The master side drives beats and result-ready; the slave side is the accumulator.
interface fixed_accumulator_if #(
    parameter int IN_WIDTH  = 34,
    parameter int OUT_WIDTH = 36
);
    logic [IN_WIDTH-1:0]  data_in;
    logic                 data_in_valid;
    logic                 data_in_ready;
    logic [OUT_WIDTH-1:0] data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid
    );

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid
    );
endinterface

// File: rtl/fixed_accumulator.sv
// Sums IN_DEPTH consecutive unsigned beats into one registered result over valid/ready.
// Build option FIXED_ACCUMULATOR_SATURATE_EN clamps a too-wide result to all-ones instead of wrapping.
module fixed_accumulator #(
    parameter int IN_DEPTH  = 4,
    parameter int IN_WIDTH  = 34,
    parameter int OUT_WIDTH = $clog2(IN_DEPTH) + IN_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    fixed_accumulator_if.slave bus
);
    localparam int ACC_W = IN_WIDTH + $clog2(IN_DEPTH);
    localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_DEPTH - 1);
`ifdef FIXED_ACCUMULATOR_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
    logic                 data_out_valid_q, data_out_valid_d;
    logic                 is_last, xfer, clip;
    logic [ACC_W-1:0]     sum_full;
    logic [OUT_WIDTH-1:0] result;

    assign is_last           = (cnt_q == CNT_LAST);
    // Only the closing beat of a group needs the output register, so only it is back-pressured.
    assign bus.data_in_ready = !(is_last && data_out_valid_q && !bus.data_out_ready);
    assign xfer              = bus.data_in_valid && bus.data_in_ready;

    // A group start ignores stale acc contents, so no separate clear cycle is needed.
    assign sum_full = ((cnt_q == '0) ? '0 : acc_q) + ACC_W'(bus.data_in);

    // The shift is zero whenever OUT_WIDTH already covers the accumulator, so clipping never fires there.
    assign clip   = SAT_EN && ((sum_full >> OUT_WIDTH) != '0);
    assign result = clip ? '1 : OUT_WIDTH'(sum_full);

    always_comb begin
        cnt_d            = cnt_q;
        acc_d            = acc_q;
        data_out_d       = data_out_q;
        data_out_valid_d = data_out_valid_q;
        if (data_out_valid_q && bus.data_out_ready) begin
            data_out_valid_d = 1'b0;
        end
        if (xfer) begin
            if (is_last) begin
                data_out_d       = result;
                data_out_valid_d = 1'b1;
                cnt_d            = '0;
            end else begin
                acc_d = sum_full;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q            <= '0;
            acc_q            <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            cnt_q            <= cnt_d;
            acc_q            <= acc_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.data_out_valid = data_out_valid_q;
endmodule
